// File: rtl/rte_pkg.sv
// rte_pkg -- shared definitions for the RTE stack.
//   op encodings : OP_NOP, OP_PUSH, OP_POP, OP_REPLACE (2-bit command field)
//   defaults     : DEFAULT_DEPTH (entries), DEFAULT_DW (entry width)
package rte_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_DW    = 8;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

endpackage

// File: rtl/rte_stack_ram.sv
// rte_stack_ram -- DEPTH x DW register file backing the stack.
//   clk   : write clock
//   we    : write enable, sampled on rising edge
//   waddr : write address
//   wdata : write data
//   raddr : combinational read address
//   rdata : combinational read data (mem[raddr])
// Contents are not reset; the owner only reads entries below the live depth.
module rte_stack_ram
    import rte_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_DW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rte_stack.sv
// rte_stack -- LIFO stack for the RTE parsing stage.
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset
//   cycle   : phase bit, 1 = execute (commands accepted), 0 = transition (NOP)
//   op      : 00 NOP, 01 PUSH, 10 POP, 11 REPLACE
//   din     : push / replace data
//   clr_err : clears sticky ovf/unf (an error on the same edge wins)
//   top     : top-of-stack entry, 0 when empty
//   stack0  : top[0]
//   depth   : entry count 0..DEPTH
//   empty   : depth == 0
//   full    : depth == DEPTH
//   ovf     : sticky, set by PUSH while full
//   unf     : sticky, set by POP while empty
// All outputs come from the registered depth/flags and the RAM contents;
// op and din only reach state through the clock edge.
module rte_stack
    import rte_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_DW,
    localparam int AW   = $clog2(DEPTH),
    localparam int DPW  = AW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cycle,
    input  logic [1:0]     op,
    input  logic [DW-1:0]  din,
    input  logic           clr_err,
    output logic [DW-1:0]  top,
    output logic           stack0,
    output logic [DPW-1:0] depth,
    output logic           empty,
    output logic           full,
    output logic           ovf,
    output logic           unf
);

    op_t            op_s;
    logic [DPW-1:0] depth_q;
    logic [DPW-1:0] depth_n;
    logic           ovf_q;
    logic           unf_q;
    logic           ovf_ev;
    logic           unf_ev;
    logic           is_empty;
    logic           is_full;
    logic           we_cmd;
    logic           ram_we;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  top_addr;
    logic [DW-1:0]  rdata;

    assign op_s     = op_t'(op);
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DPW'(DEPTH));

    // Index of the current top entry. When full the low AW bits of depth
    // are zero, so the subtraction wraps to DEPTH-1 as intended; when empty
    // the value is unused because top is forced to zero.
    assign top_addr = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        depth_n = depth_q;
        we_cmd  = 1'b0;
        waddr   = depth_q[AW-1:0];
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (cycle) begin
            case (op_s)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_ev = 1'b1;
                    end else begin
                        we_cmd  = 1'b1;
                        waddr   = depth_q[AW-1:0];
                        depth_n = depth_q + DPW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        depth_n = depth_q - DPW'(1);
                    end
                end
                OP_REPLACE: begin
                    // On an empty stack a replace has nothing to pop and
                    // degenerates to a plain push into slot 0.
                    we_cmd = 1'b1;
                    if (is_empty) begin
                        waddr   = '0;
                        depth_n = DPW'(1);
                    end else begin
                        waddr   = top_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset overrides any command on the same edge, including the write.
    assign ram_we = we_cmd & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_n;
            // Set wins over clear when both happen on one edge.
            ovf_q   <= ovf_ev | (ovf_q & ~clr_err);
            unf_q   <= unf_ev | (unf_q & ~clr_err);
        end
    end

    rte_stack_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (rdata)
    );

    // Masking with depth keeps stale entries invisible after reset.
    assign top    = is_empty ? '0 : rdata;
    assign stack0 = top[0];
    assign depth  = depth_q;
    assign empty  = is_empty;
    assign full   = is_full;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: doc/rte_stack.md
RTE_STACK -- requirements
Module: rte_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of 8-bit stack entries; power of two, 4..64.
REQ-002 Parameter DW, default 8, entry width; matches the parsing stage data byte.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cycle  input  1  phase bit shared with the parsing stage; 1 = execute (E) phase, 0 = transition (T) phase.
REQ-006 op  input  2  stack command: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE (pop then push, same edge).
REQ-007 din  input  DW  push/replace data, taken from the parsing stage B-side output byte.
REQ-008 clr_err  input  1  clears the sticky error flags.
REQ-009 top  output  DW  current top-of-stack entry; 0 when empty.
REQ-010 stack0  output  1  top[0]; feeds the parsing stage HI mux.
REQ-011 depth  output  log2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-012 empty, full  output  1 each  depth==0 and depth==DEPTH respectively.
REQ-013 ovf, unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 op shall be sampled only on rising edges where cycle==1; with cycle==0 it shall be treated as NOP.
REQ-015 PUSH, not full: mem[depth]<=din, depth<=depth+1; top shall show din from the next cycle.
REQ-016 POP, not empty: depth<=depth-1; top shall show mem[depth-2] (or 0 if now empty) from the next cycle.
REQ-017 REPLACE, not empty: mem[depth-1]<=din, depth unchanged; top shall show din from the next cycle.
REQ-018 REPLACE when empty: treated as PUSH; no error raised.
REQ-019 PUSH when full: stack and depth unchanged, ovf<=1.
REQ-020 POP when empty: stack and depth unchanged, unf<=1.
REQ-021 REPLACE when full: legal, executes per REQ-017, no error.
REQ-022 top, stack0, depth, empty, full shall be registered or derived combinationally from registered state only; no combinational path from op/din to any output.
REQ-023 Latency: each command takes effect one clock after the accepting edge; back-to-back commands on consecutive E phases shall be accepted with no stall.
REQ-024 clr_err shall clear ovf and unf on the next edge regardless of cycle; if an error event occurs on that same edge, the flag shall be set (set wins).
REQ-025 depth arithmetic shall be log2(DEPTH)+1 bits unsigned and never wrap; saturation is enforced by REQ-019/020.

Reset
REQ-026 On reset: depth=0, empty=1, full=0, top=0, stack0=0, ovf=0, unf=0.
REQ-027 Storage array contents need not be cleared; no read path shall expose stale entries after reset.
REQ-028 reset shall take priority over every command, including a command on the same edge; a reset in the middle of a sequence discards all entries.

Structure
REQ-029 Shared package rte_pkg shall hold the op encodings (OP_NOP, OP_PUSH, OP_POP, OP_REPLACE) and the default DEPTH/DW constants.
REQ-030 Storage shall be one sub-module, rte_stack_ram: a DEPTH x DW register file with one synchronous write port and one combinational read port; pointer/flag logic stays in rte_stack.

Verification
REQ-031 reset, then PUSH 0x35, 0xA2, 0x07 on three E phases -> depth=3, top=0x07, stack0=1, empty=0.
REQ-032 From REQ-031 state: POP, POP -> top=0x35, stack0=1, depth=1; POP -> empty=1, top=0; POP -> unf=1, depth=0.
REQ-033 Fill DEPTH=16 entries (0x00..0x0F) -> full=1; PUSH 0xFF -> ovf=1, top=0x0F; REPLACE 0x80 -> top=0x80, stack0=0, depth=16.
REQ-034 Drive PUSH 0x11 with cycle=0 for 4 edges -> depth stays 0; same op with cycle=1 -> depth=1, top=0x11.
REQ-035 With ovf=1, assert clr_err on the same edge as a PUSH while full -> ovf remains 1; clr_err alone on the next edge -> ovf=0.
REQ-036 Assert reset on the same edge as PUSH 0x55 with depth=5 -> depth=0, top=0, flags cleared, 0x55 not stored.
